// File: rtl/shift_slice_pipe_if.sv
// shift_slice_pipe_if: handshake bundle for shift_slice_pipe
// Input side:  in_valid, in_ready, in_data, in_shift (one-hot), in_mode
// Output side: out_valid, out_ready, out_data, out_err, err_count
// slave is the pipe's view, master is the producer/consumer view.
interface shift_slice_pipe_if #(
    parameter int LEN           = 8,
    parameter int MAX_SHIFT_MAG = 2,
    parameter int ERR_CNT_W     = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [0:LEN-1]             in_data;
    logic [0:2*MAX_SHIFT_MAG]   in_shift;
    logic [1:0]                 in_mode;
    logic                       out_valid;
    logic                       out_ready;
    logic [0:LEN-1]             out_data;
    logic                       out_err;
    logic [ERR_CNT_W-1:0]       err_count;
    modport slave (
        input  in_valid, in_data, in_shift, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err, err_count
    );
    modport master (
        output in_valid, in_data, in_shift, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err, err_count
    );
endinterface

// File: rtl/shift_slice_pipe.sv
// shift_slice_pipe: two-stage pipelined one-hot shift array with fill modes
// Ports: clk, rst (async, active-high), bus (slave modport of shift_slice_pipe_if)
// Stage A holds the operand, select and mode; stage B holds the result and err flag.
module shift_slice_pipe #(
    parameter int LEN           = 8,
    parameter int MAX_SHIFT_MAG = 2,
    parameter int ERR_CNT_W     = 8
) (
    input logic                clk,
    input logic                rst,
    shift_slice_pipe_if.slave  bus
);
    localparam int NSEL = 2 * MAX_SHIFT_MAG + 1;
    localparam int IW   = $clog2(LEN);

    logic                 a_valid, b_valid, a_adv, b_adv, a_err, b_err;
    logic [0:LEN-1]       a_data, b_data, res;
    logic [0:NSEL-1]      a_shift;
    logic [1:0]           a_mode;
    logic [ERR_CNT_W-1:0] err_count;
    logic [0:NSEL-1]      hit [0:LEN-1];

    // Out-of-range sources wrap once at most, since |k| never exceeds LEN-1.
    function automatic logic src_bit(logic [0:LEN-1] d, logic [1:0] m, int s);
        logic [IW-1:0] w;
        w = IW'(s < 0 ? s + LEN : (s >= LEN ? s - LEN : s));
        return (s >= 0 && s < LEN) || m == 2'b10 ? d[w] : (m == 2'b01 && s < 0) ? d[0] : 1'b0;
    endfunction

    assign a_err = ~$onehot(a_shift);

    // Each output bit ORs the candidate source of every select line; legality gates the result.
    for (genvar j = 0; j < LEN; j++) begin : g_bit
        for (genvar i = 0; i < NSEL; i++) begin : g_sel
            assign hit[j][i] = a_shift[i] & src_bit(a_data, a_mode, j + i - MAX_SHIFT_MAG);
        end
        assign res[j] = ~a_err & (|hit[j]);
    end

    assign b_adv         = ~b_valid | bus.out_ready;
    assign a_adv         = ~a_valid | b_adv;
    assign bus.in_ready  = a_adv;
    assign bus.out_valid = b_valid;
    assign bus.out_data  = b_data;
    assign bus.out_err   = b_err;
    assign bus.err_count = err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid   <= 1'b0;
            a_data    <= '0;
            a_shift   <= '0;
            a_mode    <= '0;
            b_valid   <= 1'b0;
            b_data    <= '0;
            b_err     <= 1'b0;
            err_count <= '0;
        end else begin
            if (a_adv) begin
                a_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    a_data  <= bus.in_data;
                    a_shift <= bus.in_shift;
                    a_mode  <= bus.in_mode;
                end
            end
            // Result registers only load on a real beat so an empty pipe keeps its last output.
            if (b_adv) begin
                b_valid <= a_valid;
                if (a_valid) begin
                    b_data <= res;
                    b_err  <= a_err;
                end
            end
            if (bus.in_valid && a_adv && !$onehot(bus.in_shift) && !(&err_count))
                err_count <= err_count + 1'b1;
        end
    end
endmodule
